// File: rtl/edf_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : edf_queue_scheduler
// Purpose  : Earliest-deadline-first drain scheduler for the multi-queue
//            packet buffer. Keeps a saturating time-to-deadline counter per
//            queue. When idle, it selects the non-empty queue with the
//            smallest counter and steers the shared BRAM read port to it.
//            It then captures the read data (1-cycle latency), offers the
//            packet downstream and pops the queue head on acceptance.
// Ports    : clock, reset (async, active-low), enable
//            queues_period              per-queue relative deadline
//            empty                      per-queue empty flags
//            queues_to_selector_packets BRAM read data
//            core_id                    selected queue (BRAM addr / pool)
//            scheduler_to_queues_consumed one-hot pop pulse
//            m_packet/m_valid/m_ready   downstream handshake
//            busy                       high outside IDLE
// Revision : 1.0  initial release
// ============================================================================
module edf_queue_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32,
    parameter int DATA_SIZE        = 678
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                enable,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]      queues_period,
    input  logic [NUMBER_OF_QUEUES-1:0]                         empty,
    input  logic [DATA_SIZE-1:0]                                queues_to_selector_packets,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]                 core_id,
    output logic [NUMBER_OF_QUEUES-1:0]                         scheduler_to_queues_consumed,
    output logic [DATA_SIZE-1:0]                                m_packet,
    output logic                                                m_valid,
    input  logic                                                m_ready,
    output logic                                                busy
);

    localparam int QW = $clog2(NUMBER_OF_QUEUES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ADDR    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_OFFER   = 2'd3;

    localparam logic [REGISTER_SIZE-1:0] C_ONE = 1;

    logic [1:0]                                     state_q, state_d;
    logic [QW-1:0]                                  core_id_q, core_id_d;
    logic [DATA_SIZE-1:0]                           m_packet_q, m_packet_d;
    logic                                           m_valid_q, m_valid_d;
    logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] ttd_q, ttd_d;

    logic                                           sel_found;
    logic [QW-1:0]                                  sel_win;
    logic [REGISTER_SIZE-1:0]                       sel_min;
    logic                                           handshake;
    logic [NUMBER_OF_QUEUES-1:0]                    consumed;

    assign handshake = (state_q == S_OFFER) && m_ready;

    // Linear minimum search. The strict '<' keeps the earlier (lower index)
    // candidate on ties.
    always_comb begin
        sel_found = 1'b0;
        sel_win   = '0;
        sel_min   = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (!empty[i] && (!sel_found || (ttd_q[i] < sel_min))) begin
                sel_found = 1'b1;
                sel_win   = i[QW-1:0];
                sel_min   = ttd_q[i];
            end
        end
    end

    // The reload on service takes precedence over the saturating decrement.
    // consumed is decoded from the held core_id, so the queue domain sees the
    // pop and the slot index in the same cycle.
    always_comb begin
        ttd_d    = ttd_q;
        consumed = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (handshake && (core_id_q == i[QW-1:0])) begin
                ttd_d[i]    = queues_period[i];
                consumed[i] = 1'b1;
            end else if (ttd_q[i] != '0) begin
                ttd_d[i] = ttd_q[i] - C_ONE;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        core_id_d  = core_id_q;
        m_packet_d = m_packet_q;
        m_valid_d  = m_valid_q;
        case (state_q)
            S_IDLE: begin
                if (enable && sel_found) begin
                    core_id_d = sel_win;
                    state_d   = S_ADDR;
                end
            end
            // BRAM samples core_id at the end of this cycle.
            S_ADDR: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                m_packet_d = queues_to_selector_packets;
                m_valid_d  = 1'b1;
                state_d    = S_OFFER;
            end
            S_OFFER: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            core_id_q  <= '0;
            m_packet_q <= '0;
            m_valid_q  <= 1'b0;
            ttd_q      <= '0;
        end else begin
            state_q    <= state_d;
            core_id_q  <= core_id_d;
            m_packet_q <= m_packet_d;
            m_valid_q  <= m_valid_d;
            ttd_q      <= ttd_d;
        end
    end

    assign core_id                      = core_id_q;
    assign m_packet                     = m_packet_q;
    assign m_valid                      = m_valid_q;
    assign busy                         = (state_q != S_IDLE);
    assign scheduler_to_queues_consumed = consumed;

endmodule
`default_nettype wire

// File: tb/tb_edf_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_edf_queue_scheduler
// Purpose  : Self-checking bench for edf_queue_scheduler. Models the queue
//            domain (occupancy counts, head data, 1-cycle BRAM) and tracks
//            each queue's deadline as an absolute edge number, so urgency is
//            max(0, deadline - now). Checks transaction timing, packet data,
//            pop pulses, EDF order, backpressure, enable gating and async reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_edf_queue_scheduler;

    localparam int NQ = 4;
    localparam int RS = 32;
    localparam int DW = 678;
    localparam int QW = 2;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [NQ-1:0][RS-1:0]    period;
    logic [NQ-1:0]            empty;
    logic [DW-1:0]            rd_data;
    logic [QW-1:0]            core_id;
    logic [NQ-1:0]            consumed;
    logic [DW-1:0]            m_packet;
    logic                     m_valid;
    logic                     m_ready;
    logic                     busy;

    always #5 clock = ~clock;

    edf_queue_scheduler #(
        .NUMBER_OF_QUEUES (NQ),
        .REGISTER_SIZE    (RS),
        .DATA_SIZE        (DW)
    ) dut (
        .clock                        (clock),
        .reset                        (reset),
        .enable                       (enable),
        .queues_period                (period),
        .empty                        (empty),
        .queues_to_selector_packets   (rd_data),
        .core_id                      (core_id),
        .scheduler_to_queues_consumed (consumed),
        .m_packet                     (m_packet),
        .m_valid                      (m_valid),
        .m_ready                      (m_ready),
        .busy                         (busy)
    );

    logic [DW-1:0] head [NQ];
    int            cnt [NQ];
    longint        deadline [NQ];
    longint        n = 0;
    int            total = 0;
    int            bad = 0;

    // Free-running edge counter and the 1-cycle-latency BRAM read port.
    always @(posedge clock) begin
        n       <= n + 1;
        rd_data <= head[core_id];
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_pkt();
        logic [703:0] t;
        for (int j = 0; j < 22; j++) t[j*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    task automatic set_empty();
        for (int i = 0; i < NQ; i++) empty[i] = (cnt[i] == 0);
    endtask

    function automatic longint ttd(input int q);
        return (deadline[q] > n) ? (deadline[q] - n) : 64'd0;
    endfunction

    // Earliest deadline among non-empty queues, lowest index on ties.
    function automatic int pick();
        int best;
        best = -1;
        for (int i = 0; i < NQ; i++)
            if (cnt[i] > 0 && (best < 0 || ttd(i) < ttd(best))) best = i;
        return best;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        m_ready = 1'b0;
        reset   = 1'b0;
        for (int i = 0; i < NQ; i++) deadline[i] = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Entered at a negedge with the DUT idle, enable=1 and a candidate present.
    task automatic serve(input int delay, input bit drop_en);
        int            w;
        logic [NQ-1:0] exp_c;
        w = pick();
        check("idle_busy", busy, 1'b0);
        @(posedge clock);
        #1;
        if (drop_en) enable = 1'b0;
        @(negedge clock);
        check("addr_busy", busy, 1'b1);
        check("addr_core_id", core_id, w[QW-1:0]);
        check("addr_valid", m_valid, 1'b0);
        @(negedge clock);
        check("capt_valid", m_valid, 1'b0);
        check("capt_core_id", core_id, w[QW-1:0]);
        @(negedge clock);
        check("offer_valid", m_valid, 1'b1);
        check("offer_packet", m_packet, head[w]);
        for (int k = 0; k < delay; k++) begin
            check("bp_consumed", consumed, '0);
            check("bp_valid", m_valid, 1'b1);
            check("bp_core_id", core_id, w[QW-1:0]);
            check("bp_packet", m_packet, head[w]);
            @(negedge clock);
        end
        m_ready = 1'b1;
        #1;
        exp_c    = '0;
        exp_c[w] = 1'b1;
        check("hs_consumed", consumed, exp_c);
        check("hs_core_id", core_id, w[QW-1:0]);
        @(posedge clock);
        #1;
        m_ready     = 1'b0;
        deadline[w] = n + longint'(period[w]);
        cnt[w]--;
        head[w] = rnd_pkt();
        set_empty();
        @(negedge clock);
        check("post_valid", m_valid, 1'b0);
        check("post_consumed", consumed, '0);
        check("post_busy", busy, 1'b0);
    endtask

    initial begin
        int w;
        logic [703:0] a5;
        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        period  = '0;
        for (int i = 0; i < NQ; i++) begin
            cnt[i]      = 0;
            head[i]     = rnd_pkt();
            deadline[i] = 0;
        end
        set_empty();
        #3 reset = 1'b0;
        repeat (3) @(negedge clock);
        reset  = 1'b1;
        enable = 1'b1;

        // Idle with nothing to serve.
        repeat (20) begin
            @(negedge clock);
            check("rst_core_id", core_id, '0);
            check("rst_valid", m_valid, 1'b0);
            check("rst_consumed", consumed, '0);
            check("rst_busy", busy, 1'b0);
        end

        // Single queue with a recognisable pattern.
        a5        = {88{8'hA5}};
        head[2]   = a5[DW-1:0];
        cnt[2]    = 1;
        period[2] = 17;
        set_empty();
        serve(0, 1'b0);
        repeat (3) begin
            @(negedge clock);
            check("drained_busy", busy, 1'b0);
        end

        // Enable gating, then enable dropped during ADDR.
        enable = 1'b0;
        cnt[0] = 2;
        cnt[3] = 1;
        set_empty();
        repeat (5) begin
            @(negedge clock);
            check("gated_busy", busy, 1'b0);
        end
        enable = 1'b1;
        serve(0, 1'b1);
        repeat (3) begin
            @(negedge clock);
            check("gated_after_busy", busy, 1'b0);
        end
        enable = 1'b1;

        // Backpressure for 7 cycles.
        serve(7, 1'b0);

        // Async reset while offering: nothing popped, state cleared at once.
        w = pick();
        repeat (3) @(negedge clock);
        check("pre_rst_valid", m_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", m_valid, 1'b0);
        check("arst_core_id", core_id, '0);
        check("arst_busy", busy, 1'b0);
        check("arst_consumed", consumed, '0);
        check("arst_packet", m_packet, '0);
        for (int i = 0; i < NQ; i++) deadline[i] = 0;
        @(negedge clock);
        check("arst_consumed2", consumed, '0);
        reset = 1'b1;
        serve(0, 1'b0);

        // EDF ordering with fixed periods.
        do_reset();
        period[0] = 100;
        period[1] = 10;
        period[2] = 50;
        period[3] = 30;
        for (int i = 0; i < NQ; i++) cnt[i] = 50;
        set_empty();
        repeat (16) serve(0, 1'b0);

        // Randomised traffic, periods (including zero) and backpressure.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0)
                period[$urandom_range(0, NQ-1)] = $urandom_range(0, 60);
            if ($urandom_range(0, 1) == 1)
                cnt[$urandom_range(0, NQ-1)] += 1;
            if (pick() < 0) cnt[$urandom_range(0, NQ-1)] = 1;
            set_empty();
            serve($urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
